// File: rtl/fir_hls_sdiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// fir_hls_div_pkg
//   Shared widths, FSM state type, saturation limits and magnitude helpers for
//   the sequential signed divider fir_hls_sdiv_seq.
//   Optional feature macro used by the divider files: FIR_HLS_SDIV_REM_EN.
//   No ports (package).
// ---------------------------------------------------------------------------
package fir_hls_div_pkg;

    localparam int DIVIDEND_W = 42;
    localparam int DIVISOR_W  = 10;
    localparam int QUOT_W     = 32;

    // Partial remainder is one bit wider than the divisor magnitude so the
    // shifted-in trial value never loses its top bit.
    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitudes are kept unsigned at full width, so the most negative value
    // maps onto its exact positive magnitude (e.g. -512 -> 10'h200 = 512).
    function automatic logic [DIVIDEND_W-1:0] abs_dividend(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? -v : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs_divisor(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? -v : v;
    endfunction

    function automatic logic [QUOT_W-1:0] neg_quot(input logic [QUOT_W-1:0] v);
        return -v;
    endfunction

endpackage

// File: rtl/fir_hls_sdiv_seq_if.sv
// ---------------------------------------------------------------------------
// fir_hls_sdiv_seq_if
//   Operand / result bundle of the sequential signed divider.
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The source holds valid and its data stable until that edge;
//   ready may be observed before valid rises. out_valid is held, with stable
//   result fields, until out_ready is seen.
//   Signals:
//     in_valid/in_ready/dividend/divisor     operand side
//     out_valid/out_ready/quotient/div0/ovf  result side
//     remainder                              only with FIR_HLS_SDIV_REM_EN
//     dbg_state                              current FSM state for observers
//   master: operand producer and result consumer; slave: the divider.
// ---------------------------------------------------------------------------
interface fir_hls_sdiv_seq_if;
    import fir_hls_div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quotient;
    logic                  div0;
    logic                  ovf;
    div_state_t            dbg_state;
`ifdef FIR_HLS_SDIV_REM_EN
    logic [DIVISOR_W-1:0]  remainder;
`endif

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, div0, ovf, dbg_state
`ifdef FIR_HLS_SDIV_REM_EN
        , input remainder
`endif
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, div0, ovf, dbg_state
`ifdef FIR_HLS_SDIV_REM_EN
        , output remainder
`endif
    );

endinterface

// File: rtl/fir_hls_sdiv_seq_satfix.sv
// ---------------------------------------------------------------------------
// fir_hls_div_satfix
//   Combinational sign application and saturation of the unsigned quotient
//   magnitude produced by the shift-subtract loop.
//   Ports:
//     q_mag_i    full-width quotient magnitude
//     q_neg_i    result is negative (operand signs differ)
//     div0_i     divisor was zero
//     num_neg_i  dividend was negative (selects the div0 saturation value)
//     quot_o     signed, saturated quotient
//     ovf_o      true quotient was outside the quotient range
// ---------------------------------------------------------------------------
module fir_hls_div_satfix
    import fir_hls_div_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] q_mag_i,
    input  logic                  q_neg_i,
    input  logic                  div0_i,
    input  logic                  num_neg_i,
    output logic [QUOT_W-1:0]     quot_o,
    output logic                  ovf_o
);

    // A negative result may reach a magnitude one larger than a positive one.
    localparam logic [DIVIDEND_W-1:0] POS_LIM = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMAX};
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMIN};

    always_comb begin
        quot_o = '0;
        ovf_o  = 1'b0;
        if (div0_i) begin
            // Divide-by-zero saturates toward the dividend's sign; not an overflow.
            quot_o = num_neg_i ? QMIN : QMAX;
        end else if (q_neg_i) begin
            if (q_mag_i > NEG_LIM) begin
                quot_o = QMIN;
                ovf_o  = 1'b1;
            end else begin
                quot_o = neg_quot(q_mag_i[QUOT_W-1:0]);
            end
        end else begin
            if (q_mag_i > POS_LIM) begin
                quot_o = QMAX;
                ovf_o  = 1'b1;
            end else begin
                quot_o = q_mag_i[QUOT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_hls_sdiv_seq.sv
// ---------------------------------------------------------------------------
// fir_hls_sdiv_seq
//   Sequential signed divider, 42-bit dividend / 10-bit divisor -> 32-bit
//   saturated quotient truncated toward zero. Restoring shift-subtract, one
//   quotient bit per clock.
//   FSM: IDLE -> CALC (42 cycles) -> FIX -> DONE, or IDLE -> FIX on a zero
//   divisor. Results are registered in FIX and held in DONE until out_ready.
//   Optional feature: define FIR_HLS_SDIV_REM_EN to add the signed remainder
//   output (sign follows the dividend).
//   Ports:
//     ap_clk  clock, all state on the rising edge
//     ap_rst  synchronous active-high reset; aborts any operation in flight
//     bus     fir_hls_sdiv_seq_if.slave operand/result bundle
// ---------------------------------------------------------------------------
module fir_hls_sdiv_seq
    import fir_hls_div_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,
    fir_hls_sdiv_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    div_state_t state_q, state_d;

    // num_q starts as the dividend magnitude; quotient bits shift in at the
    // bottom as dividend bits leave the top, so after the loop it holds the
    // quotient magnitude.
    logic [DIVIDEND_W-1:0] num_q;
    logic [DIVISOR_W-1:0]  den_q;
    logic [REM_W-1:0]      rem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  nsign_q;
    logic                  dsign_q;
    logic                  zero_q;

    logic [QUOT_W-1:0]     quot_q;
    logic                  div0_q;
    logic                  ovf_q;

    logic                  accept;
    logic [REM_W:0]        rem_trial;
    logic                  rem_ge;
    logic [QUOT_W-1:0]     quot_fix;
    logic                  ovf_fix;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign rem_trial = {rem_q, num_q[DIVIDEND_W-1]};
    assign rem_ge    = rem_trial >= {2'b00, den_q};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (bus.divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.dbg_state = state_q;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            nsign_q <= 1'b0;
            dsign_q <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        num_q   <= abs_dividend(bus.dividend);
                        den_q   <= abs_divisor(bus.divisor);
                        nsign_q <= bus.dividend[DIVIDEND_W-1];
                        dsign_q <= bus.divisor[DIVISOR_W-1];
                        zero_q  <= (bus.divisor == '0);
                        rem_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    rem_q <= rem_ge ? REM_W'(rem_trial - {2'b00, den_q})
                                    : rem_trial[REM_W-1:0];
                    num_q <= {num_q[DIVIDEND_W-2:0], rem_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    quot_q <= quot_fix;
                    ovf_q  <= ovf_fix;
                    div0_q <= zero_q;
                end
                default: ;
            endcase
        end
    end

    fir_hls_div_satfix u_satfix (
        .q_mag_i   (num_q),
        .q_neg_i   (nsign_q ^ dsign_q),
        .div0_i    (zero_q),
        .num_neg_i (nsign_q),
        .quot_o    (quot_fix),
        .ovf_o     (ovf_fix)
    );

    assign bus.quotient = quot_q;
    assign bus.div0     = div0_q;
    assign bus.ovf      = ovf_q;

`ifdef FIR_HLS_SDIV_REM_EN
    // On a zero divisor the loop never ran; negating the low magnitude bits
    // by the dividend sign reproduces dividend[DIVISOR_W-1:0] exactly.
    logic [DIVISOR_W-1:0] rem_mag;
    logic [DIVISOR_W-1:0] rem_out_q;

    assign rem_mag = zero_q ? num_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rem_out_q <= '0;
        end else if (state_q == FIX) begin
            rem_out_q <= nsign_q ? -rem_mag : rem_mag;
        end
    end

    assign bus.remainder = rem_out_q;
`endif

endmodule
